// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: controller state
// encodings, branch/jump type codes and the default resolve-stage index.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MDU_WAIT = 2'b01,
    ST_SHADOW   = 2'b10
  } hz_state_e;

  localparam logic [1:0] BJ_NONE   = 2'b00;
  localparam logic [1:0] BJ_BRANCH = 2'b01;
  localparam logic [1:0] BJ_JAL    = 2'b10;
  localparam logic [1:0] BJ_JALR   = 2'b11;

  localparam int DEFAULT_RESOLVE_STAGE = 2;
  localparam int SHADOW_W              = 4;

endpackage

// File: rtl/hazard_stall_watchdog.sv
// Stall watchdog: counts consecutive PC-stall cycles (saturating at
// MAX_STALL) and raises a sticky timeout flag once the limit is reached.
module hazard_stall_watchdog #(
  parameter int MAX_STALL = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic stall_i,
  output logic timeout_o
);

  localparam int CW = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_STALL);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;

  // Next-state: count stall cycles, clear on any run cycle, latch the flag.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_i) begin
      if (cnt_q != MAX_C) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
    flag_d = flag_q | (cnt_d == MAX_C);
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= {CW{1'b0}};
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_o = flag_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: per-stage enable/flush vectors for an N-stage
// pipeline, with a multi-cycle MDU stall FSM, post-redirect fetch-shadow
// flushing and a stall watchdog. Define HAZARD_STATS_EN to build the
// saturating statistics counters; otherwise the counter ports read 0.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES    = 5,
  parameter int RESOLVE_STAGE = DEFAULT_RESOLVE_STAGE,
  parameter int SHADOW_CYCLES = 0,
  parameter int MAX_STALL     = 64,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_use_hazard,
  input  logic                  mdu_start,
  input  logic                  mdu_done,
  input  logic [1:0]            branch_jump_ex,
  input  logic                  pc_sel_ex,
  output logic [NUM_STAGES-1:0] stage_enable,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [1:0]            ctrl_state,
  output logic                  stall_timeout,
  output logic [CNT_W-1:0]      load_use_cnt,
  output logic [CNT_W-1:0]      mdu_stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [NUM_STAGES-1:0] ONES_C     = {NUM_STAGES{1'b1}};
  localparam logic [NUM_STAGES-1:0] ZERO_C     = {NUM_STAGES{1'b0}};
  localparam logic [NUM_STAGES-1:0] ONE_C      = {{(NUM_STAGES-1){1'b0}}, 1'b1};
  // MDU stall freezes PC..RESOLVE_STAGE and bubbles the stage after it.
  localparam logic [NUM_STAGES-1:0] MDU_EN_C   = ONES_C << (RESOLVE_STAGE + 1);
  localparam logic [NUM_STAGES-1:0] MDU_FL_C   = ONE_C << (RESOLVE_STAGE + 1);
  // Load-use freezes PC..RESOLVE_STAGE-1 and bubbles RESOLVE_STAGE.
  localparam logic [NUM_STAGES-1:0] LU_EN_C    = ONES_C << RESOLVE_STAGE;
  localparam logic [NUM_STAGES-1:0] LU_FL_C    = ONE_C << RESOLVE_STAGE;
  // Redirect kills the wrong-path instructions in stages 1..RESOLVE_STAGE.
  localparam logic [NUM_STAGES-1:0] REDIR_FL_C = (ONES_C << 1) & ~(ONES_C << (RESOLVE_STAGE + 1));
  localparam logic [NUM_STAGES-1:0] SH_FL_C    = ONE_C << 1;
  localparam logic [NUM_STAGES-1:0] RST_FL_C   = ONES_C << 1;
  localparam logic [SHADOW_W-1:0]   SH_LOAD_C  = SHADOW_W'(SHADOW_CYCLES);

  hz_state_e             state_q, state_d;
  logic [SHADOW_W-1:0]   shadow_q, shadow_d;
  logic [NUM_STAGES-1:0] en_s, fl_s;
  logic                  redirect_s;
  logic                  lu_bubble_s, mdu_stall_s, redir_acc_s;

  assign redirect_s = (branch_jump_ex != BJ_NONE) && pc_sel_ex;

  // Next-state and Mealy enable/flush decode, priority redirect > MDU > load-use.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    en_s        = ONES_C;
    fl_s        = ZERO_C;
    lu_bubble_s = 1'b0;
    mdu_stall_s = 1'b0;
    redir_acc_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect_s) begin
          fl_s        = REDIR_FL_C;
          redir_acc_s = 1'b1;
          if (SHADOW_CYCLES > 0) begin
            state_d  = ST_SHADOW;
            shadow_d = SH_LOAD_C;
          end else begin
            state_d  = ST_RUN;
          end
        end else if (mdu_start) begin
          en_s        = MDU_EN_C;
          fl_s        = MDU_FL_C;
          mdu_stall_s = 1'b1;
          state_d     = mdu_done ? ST_RUN : ST_MDU_WAIT;
        end else if (load_use_hazard) begin
          en_s        = LU_EN_C;
          fl_s        = LU_FL_C;
          lu_bubble_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MDU_WAIT: begin
        // The MDU op owns RESOLVE_STAGE, so redirect/load-use cannot apply.
        if (mdu_done) begin
          state_d = ST_RUN;
        end else begin
          en_s        = MDU_EN_C;
          fl_s        = MDU_FL_C;
          mdu_stall_s = 1'b1;
        end
      end
      ST_SHADOW: begin
        if (redirect_s) begin
          fl_s        = REDIR_FL_C;
          redir_acc_s = 1'b1;
          shadow_d    = SH_LOAD_C;
        end else if (mdu_start) begin
          en_s        = MDU_EN_C;
          fl_s        = MDU_FL_C;
          mdu_stall_s = 1'b1;
          shadow_d    = {SHADOW_W{1'b0}};
          state_d     = mdu_done ? ST_RUN : ST_MDU_WAIT;
        end else begin
          // ID holds a bubble here, so a load-use hazard cannot be real.
          fl_s = SH_FL_C;
          if (shadow_q <= SHADOW_W'(1)) begin
            shadow_d = {SHADOW_W{1'b0}};
            state_d  = ST_RUN;
          end else begin
            shadow_d = shadow_q - SHADOW_W'(1);
          end
        end
      end
      default: begin
        state_d  = ST_RUN;
        shadow_d = {SHADOW_W{1'b0}};
      end
    endcase
  end

  // Controller state and shadow counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      shadow_q <= {SHADOW_W{1'b0}};
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
    end
  end

  // While in reset every register is frozen and loaded with a bubble.
  assign stage_enable = reset_n ? en_s : ZERO_C;
  assign stage_flush  = reset_n ? fl_s : RST_FL_C;
  assign ctrl_state   = state_q;

  hazard_stall_watchdog #(
    .MAX_STALL (MAX_STALL)
  ) u_watchdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall_i   (~stage_enable[0]),
    .timeout_o (stall_timeout)
  );

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Saturating statistics next-state.
  always_comb begin
    lu_cnt_d  = lu_bubble_s ? sat_inc(lu_cnt_q)  : lu_cnt_q;
    mdu_cnt_d = mdu_stall_s ? sat_inc(mdu_cnt_q) : mdu_cnt_q;
    fl_cnt_d  = redir_acc_s ? sat_inc(fl_cnt_q)  : fl_cnt_q;
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lu_cnt_q  <= {CNT_W{1'b0}};
      mdu_cnt_q <= {CNT_W{1'b0}};
      fl_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mdu_cnt_q <= mdu_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
    end
  end

  assign load_use_cnt  = lu_cnt_q;
  assign mdu_stall_cnt = mdu_cnt_q;
  assign flush_cnt     = fl_cnt_q;
`else
  logic unused_stats_s;
  assign unused_stats_s = ^{lu_bubble_s, mdu_stall_s, redir_acc_s};
  assign load_use_cnt   = {CNT_W{1'b0}};
  assign mdu_stall_cnt  = {CNT_W{1'b0}};
  assign flush_cnt      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (NUM_STAGES=5, RESOLVE_STAGE=2,
// SHADOW_CYCLES=2, MAX_STALL=8). Inputs change 1ns after the rising edge and
// outputs are sampled on the falling edge.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_use_hazard, mdu_start, mdu_done, pc_sel_ex;
  logic [1:0]  branch_jump_ex;
  logic [4:0]  stage_enable, stage_flush;
  logic [1:0]  ctrl_state;
  logic        stall_timeout;
  logic [31:0] load_use_cnt, mdu_stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;
  int exp_lu = 0, exp_mdu = 0, exp_fl = 0;

  pipeline_hazard_ctrl #(
    .NUM_STAGES(5), .RESOLVE_STAGE(2), .SHADOW_CYCLES(2), .MAX_STALL(8), .CNT_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .load_use_hazard(load_use_hazard),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .branch_jump_ex(branch_jump_ex),
    .pc_sel_ex(pc_sel_ex), .stage_enable(stage_enable), .stage_flush(stage_flush),
    .ctrl_state(ctrl_state), .stall_timeout(stall_timeout),
    .load_use_cnt(load_use_cnt), .mdu_stall_cnt(mdu_stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load_use_hazard = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0;
    branch_jump_ex = 2'b00; pc_sel_ex = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stage_enable, stage_flush, ctrl_state, stall_timeout} !== {5'b00000, 5'b11110, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL reset_pattern got en=%b fl=%b st=%b to=%b want 00000/11110/00/0", stage_enable, stage_flush, ctrl_state, stall_timeout);
    end
    checks++;
    if ({load_use_cnt, mdu_stall_cnt, flush_cnt} !== 96'd0) begin
      failures++;
      $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", load_use_cnt, mdu_stall_cnt, flush_cnt);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({stage_enable, stage_flush, ctrl_state} !== {5'b11111, 5'b00000, 2'b00}) begin
      failures++;
      $display("FAIL run_idle got en=%b fl=%b st=%b want 11111/00000/00", stage_enable, stage_flush, ctrl_state);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    load_use_hazard = 1'b1;
    @(negedge clk);
    checks++;
    if ({stage_enable, stage_flush, ctrl_state} !== {5'b11100, 5'b00100, 2'b00}) begin
      failures++;
      $display("FAIL lu_bubble got en=%b fl=%b st=%b want 11100/00100/00", stage_enable, stage_flush, ctrl_state);
    end
    exp_lu++;
    next_cycle();
    load_use_hazard = 1'b0;
    @(negedge clk);
    checks++;
    if ({stage_enable, stage_flush} !== {5'b11111, 5'b00000}) begin
      failures++;
      $display("FAIL lu_release got en=%b fl=%b want 11111/00000", stage_enable, stage_flush);
    end
    checks++;
    if (load_use_cnt !== (STATS ? exp_lu : 0)) begin
      failures++;
      $display("FAIL lu_cnt got %0d want %0d", load_use_cnt, STATS ? exp_lu : 0);
    end
    next_cycle();
  endtask

  task automatic test_mdu();
    mdu_start = 1'b1;
    @(negedge clk);
    checks++;
    if ({stage_enable, stage_flush, ctrl_state} !== {5'b11000, 5'b01000, 2'b00}) begin
      failures++;
      $display("FAIL mdu_start got en=%b fl=%b st=%b want 11000/01000/00", stage_enable, stage_flush, ctrl_state);
    end
    exp_mdu++;
    next_cycle();
    mdu_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({stage_enable, stage_flush, ctrl_state} !== {5'b11000, 5'b01000, 2'b01}) begin
        failures++;
        $display("FAIL mdu_wait[%0d] got en=%b fl=%b st=%b want 11000/01000/01", i, stage_enable, stage_flush, ctrl_state);
      end
      exp_mdu++;
      next_cycle();
    end
    mdu_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({stage_enable, stage_flush, ctrl_state} !== {5'b11111, 5'b00000, 2'b01}) begin
      failures++;
      $display("FAIL mdu_done got en=%b fl=%b st=%b want 11111/00000/01", stage_enable, stage_flush, ctrl_state);
    end
    next_cycle();
    mdu_done = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl_state !== 2'b00) begin
      failures++;
      $display("FAIL mdu_back_to_run got st=%b want 00", ctrl_state);
    end
    checks++;
    if (mdu_stall_cnt !== (STATS ? exp_mdu : 0)) begin
      failures++;
      $display("FAIL mdu_cnt got %0d want %0d", mdu_stall_cnt, STATS ? exp_mdu : 0);
    end
    next_cycle();
  endtask

  task automatic test_mdu_same_cycle_done();
    mdu_start = 1'b1; mdu_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({stage_enable, stage_flush} !== {5'b11000, 5'b01000}) begin
      failures++;
      $display("FAIL mdu_fast_stall got en=%b fl=%b want 11000/01000", stage_enable, stage_flush);
    end
    exp_mdu++;
    next_cycle();
    mdu_start = 1'b0; mdu_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({stage_enable, ctrl_state} !== {5'b11111, 2'b00}) begin
      failures++;
      $display("FAIL mdu_fast_run got en=%b st=%b want 11111/00", stage_enable, ctrl_state);
    end
    next_cycle();
  endtask

  task automatic test_not_taken();
    branch_jump_ex = 2'b01; pc_sel_ex = 1'b0;
    @(negedge clk);
    checks++;
    if ({stage_enable, stage_flush} !== {5'b11111, 5'b00000}) begin
      failures++;
      $display("FAIL not_taken got en=%b fl=%b want 11111/00000", stage_enable, stage_flush);
    end
    next_cycle();
    branch_jump_ex = 2'b00; pc_sel_ex = 1'b1;
    @(negedge clk);
    checks++;
    if ({stage_flush, ctrl_state} !== {5'b00000, 2'b00}) begin
      failures++;
      $display("FAIL sel_no_branch got fl=%b st=%b want 00000/00", stage_flush, ctrl_state);
    end
    next_cycle();
    pc_sel_ex = 1'b0;
  endtask

  task automatic test_redirect_shadow();
    branch_jump_ex = 2'b01; pc_sel_ex = 1'b1;
    @(negedge clk);
    checks++;
    if ({stage_enable, stage_flush, ctrl_state} !== {5'b11111, 5'b00110, 2'b00}) begin
      failures++;
      $display("FAIL redirect got en=%b fl=%b st=%b want 11111/00110/00", stage_enable, stage_flush, ctrl_state);
    end
    exp_fl++;
    next_cycle();
    branch_jump_ex = 2'b00; pc_sel_ex = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({stage_enable, stage_flush, ctrl_state} !== {5'b11111, 5'b00010, 2'b10}) begin
        failures++;
        $display("FAIL shadow[%0d] got en=%b fl=%b st=%b want 11111/00010/10", i, stage_enable, stage_flush, ctrl_state);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if ({stage_flush, ctrl_state} !== {5'b00000, 2'b00}) begin
      failures++;
      $display("FAIL shadow_exit got fl=%b st=%b want 00000/00", stage_flush, ctrl_state);
    end
    checks++;
    if (flush_cnt !== (STATS ? exp_fl : 0)) begin
      failures++;
      $display("FAIL flush_cnt got %0d want %0d", flush_cnt, STATS ? exp_fl : 0);
    end
    next_cycle();
  endtask

  task automatic test_redirect_vs_load_use();
    branch_jump_ex = 2'b10; pc_sel_ex = 1'b1; load_use_hazard = 1'b1;
    @(negedge clk);
    checks++;
    if ({stage_enable, stage_flush} !== {5'b11111, 5'b00110}) begin
      failures++;
      $display("FAIL redir_wins got en=%b fl=%b want 11111/00110", stage_enable, stage_flush);
    end
    exp_fl++;
    next_cycle();
    branch_jump_ex = 2'b00; pc_sel_ex = 1'b0;
    @(negedge clk);
    checks++;
    if ({stage_enable, stage_flush, ctrl_state} !== {5'b11111, 5'b00010, 2'b10}) begin
      failures++;
      $display("FAIL shadow_ignores_lu got en=%b fl=%b st=%b want 11111/00010/10", stage_enable, stage_flush, ctrl_state);
    end
    next_cycle();
    load_use_hazard = 1'b0; mdu_start = 1'b1;
    @(negedge clk);
    checks++;
    if ({stage_enable, stage_flush, ctrl_state} !== {5'b11000, 5'b01000, 2'b10}) begin
      failures++;
      $display("FAIL shadow_mdu got en=%b fl=%b st=%b want 11000/01000/10", stage_enable, stage_flush, ctrl_state);
    end
    exp_mdu++;
    next_cycle();
    mdu_start = 1'b0; mdu_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({stage_enable, ctrl_state} !== {5'b11111, 2'b01}) begin
      failures++;
      $display("FAIL shadow_to_mdu got en=%b st=%b want 11111/01", stage_enable, ctrl_state);
    end
    next_cycle();
    mdu_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_use_cnt, flush_cnt} !== {(STATS ? 32'(exp_lu) : 32'd0), (STATS ? 32'(exp_fl) : 32'd0)}) begin
      failures++;
      $display("FAIL lu_fl_cnt got %0d/%0d want %0d/%0d", load_use_cnt, flush_cnt, STATS ? exp_lu : 0, STATS ? exp_fl : 0);
    end
    next_cycle();
  endtask

  task automatic test_watchdog();
    mdu_start = 1'b1;
    @(negedge clk);
    exp_mdu++;
    next_cycle();
    mdu_start = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      exp_mdu++;
      if (c == 8) begin
        checks++;
        if (stall_timeout !== 1'b0) begin
          failures++;
          $display("FAIL wd_early got %b want 0", stall_timeout);
        end
      end
      next_cycle();
    end
    branch_jump_ex = 2'b01; pc_sel_ex = 1'b1; load_use_hazard = 1'b1;
    @(negedge clk);
    exp_mdu++;
    checks++;
    if (stall_timeout !== 1'b1) begin
      failures++;
      $display("FAIL wd_fire got %b want 1", stall_timeout);
    end
    checks++;
    if ({stage_enable, stage_flush, ctrl_state} !== {5'b11000, 5'b01000, 2'b01}) begin
      failures++;
      $display("FAIL wait_ignores_redir got en=%b fl=%b st=%b want 11000/01000/01", stage_enable, stage_flush, ctrl_state);
    end
    next_cycle();
    branch_jump_ex = 2'b00; pc_sel_ex = 1'b0; load_use_hazard = 1'b0; mdu_done = 1'b1;
    @(negedge clk);
    next_cycle();
    mdu_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall_timeout, ctrl_state, stage_enable} !== {1'b1, 2'b00, 5'b11111}) begin
      failures++;
      $display("FAIL wd_sticky got to=%b st=%b en=%b want 1/00/11111", stall_timeout, ctrl_state, stage_enable);
    end
    checks++;
    if ({mdu_stall_cnt, flush_cnt} !== {(STATS ? 32'(exp_mdu) : 32'd0), (STATS ? 32'(exp_fl) : 32'd0)}) begin
      failures++;
      $display("FAIL wd_cnts got %0d/%0d want %0d/%0d", mdu_stall_cnt, flush_cnt, STATS ? exp_mdu : 0, STATS ? exp_fl : 0);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    mdu_start = 1'b1;
    next_cycle();
    mdu_start = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl_state !== 2'b01) begin
      failures++;
      $display("FAIL pre_reset_wait got st=%b want 01", ctrl_state);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({stage_enable, stage_flush, ctrl_state} !== {5'b00000, 5'b11110, 2'b00}) begin
      failures++;
      $display("FAIL async_reset got en=%b fl=%b st=%b want 00000/11110/00", stage_enable, stage_flush, ctrl_state);
    end
    next_cycle();
    reset_n = 1'b1;
    exp_lu = 0; exp_mdu = 0; exp_fl = 0;
    @(negedge clk);
    checks++;
    if ({load_use_cnt, mdu_stall_cnt, flush_cnt, stall_timeout} !== {96'd0, 1'b0}) begin
      failures++;
      $display("FAIL post_reset_cnts got %0d/%0d/%0d to=%b want 0/0/0/0", load_use_cnt, mdu_stall_cnt, flush_cnt, stall_timeout);
    end
    checks++;
    if ({stage_enable, stage_flush, ctrl_state} !== {5'b11111, 5'b00000, 2'b00}) begin
      failures++;
      $display("FAIL post_reset_run got en=%b fl=%b st=%b want 11111/00000/00", stage_enable, stage_flush, ctrl_state);
    end
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_mdu();
    test_mdu_same_cycle_done();
    test_not_taken();
    test_redirect_shadow();
    test_redirect_vs_load_use();
    test_watchdog();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised successor to the combinational hazard control unit for the RV32IM pipeline.
- Drives per-stage enable and flush vectors for an N-stage pipeline.
- Adds a multi-cycle MUL/DIV stall state machine, a post-redirect fetch-shadow flush counter and a stall watchdog.
- Sits between the hazard detection unit / MDU and every pipeline register plus the PC.

Parameters:
- NUM_STAGES, 5, pipeline depth (>=3); stage 0 = IF.
- RESOLVE_STAGE, 2, stage index where branches resolve and MDU ops execute (EX); 1 <= RESOLVE_STAGE <= NUM_STAGES-2.
- SHADOW_CYCLES, 0, extra cycles IF/ID keeps flushing after a redirect (multi-cycle imem); 0..15.
- MAX_STALL, 64, consecutive PC-stall cycles before watchdog fires.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_use_hazard  in  1  load-use hazard from detection unit (level)
- mdu_start  in  1  one-cycle pulse: multi-cycle MUL/DIV entered RESOLVE_STAGE
- mdu_done  in  1  one-cycle pulse: MDU result ready
- branch_jump_ex  in  2  branch/jump type in RESOLVE_STAGE; 00 = none
- pc_sel_ex  in  1  branch taken / jump
- stage_enable  out  NUM_STAGES  bit0 = PC enable; bit k = enable of the register feeding stage k
- stage_flush  out  NUM_STAGES  bit k = load bubble into the register feeding stage k; bit0 is always 0
- ctrl_state  out  2  00 RUN, 01 MDU_WAIT, 10 SHADOW
- stall_timeout  out  1  sticky watchdog flag
- load_use_cnt, mdu_stall_cnt, flush_cnt  out  CNT_W  statistics (see Optional Feature)

Behaviour:
- redirect = (branch_jump_ex != 2'b00) && pc_sel_ex.
- Default: all enables 1, all flushes 0.
- Reset (reset_n low, asynchronous): state RUN, shadow counter 0, watchdog counter 0, stall_timeout 0, statistics 0. While reset_n is low, stage_enable is all 0 and stage_flush[NUM_STAGES-1:1] is all 1.
- RUN, priority redirect > mdu_start > load_use_hazard:
  - redirect: flush bits 1..RESOLVE_STAGE; PC enabled. If SHADOW_CYCLES>0, go to SHADOW with counter = SHADOW_CYCLES.
  - mdu_start: Mealy stall in the same cycle. Enable bits 0..RESOLVE_STAGE = 0; flush bit RESOLVE_STAGE+1. Next state MDU_WAIT, unless mdu_done is asserted in the same cycle, in which case stay in RUN.
  - load_use_hazard: enable bits 0..RESOLVE_STAGE-1 = 0; flush bit RESOLVE_STAGE. Stays in RUN, so one bubble per asserted cycle.
- MDU_WAIT:
  - Without mdu_done: same stall pattern as mdu_start.
  - Cycle mdu_done is high: all enables 1, no flush; return to RUN.
  - redirect and load_use_hazard are ignored (the MDU op occupies RESOLVE_STAGE).
- SHADOW:
  - Each cycle: flush bit 1 only, PC enabled; counter decrements; exit to RUN in the cycle the counter reaches 1.
  - A new redirect reloads the counter and also flushes bits 1..RESOLVE_STAGE.
  - mdu_start is still honoured (MDU stall pattern) and moves to MDU_WAIT, abandoning the shadow.
  - load_use_hazard is ignored, because ID holds a bubble.
- Watchdog:
  - Counter increments each cycle stage_enable[0]==0, clears otherwise, and saturates at MAX_STALL.
  - On reaching MAX_STALL, stall_timeout is set and held until reset.
- Outputs are combinational from state and inputs; state, counters and stall_timeout are registered.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: three saturating CNT_W counters.
  - load_use_cnt: +1 per cycle a load-use bubble is inserted.
  - mdu_stall_cnt: +1 per MDU stall cycle.
  - flush_cnt: +1 per redirect accepted.
- Undefined: the ports remain and are tied to 0; no counter flops are inferred.

Decomposition:
- Shared package hazard_pkg holds:
  - the state encodings RUN / MDU_WAIT / SHADOW;
  - branch_jump codes;
  - DEFAULT_RESOLVE_STAGE.
- One natural sub-module: hazard_stall_watchdog (counter plus sticky flag), parametrised by MAX_STALL.

Test Plan:
- load_use_hazard held 1 cycle in RUN (NUM_STAGES=5): stage_enable = 5'b11100, stage_flush = 5'b00100 for that cycle; next cycle all enables 1.
- mdu_start, then mdu_done 4 cycles later: enable = 5'b11000 and flush = 5'b01000 for 4 cycles, ctrl_state = 01, release on the done cycle, mdu_stall_cnt = 4 with HAZARD_STATS_EN.
- Redirect (branch_jump_ex=01, pc_sel_ex=1) with SHADOW_CYCLES=2: flush = 5'b00110, then 5'b00010 for 2 cycles, ctrl_state 10 -> 00; flush_cnt = 1.
- Redirect and load_use_hazard in the same cycle: redirect wins; flush = 5'b00110, PC enabled, load_use_cnt unchanged.
- MAX_STALL=8, mdu_done withheld: stall_timeout rises on the 8th stall cycle and stays 1 after mdu_done.
- reset_n dropped mid MDU_WAIT: outputs immediately reset pattern, ctrl_state = 00, all counters 0 after release.
